// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states, big-endian
// lane offsets and request classification helpers.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        LSU_LW  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LHU = 3'd2,
        LSU_LB  = 3'd3,
        LSU_LBU = 3'd4,
        LSU_SW  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Big-endian: byte offset 0 is the most significant lane
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
    localparam logic [1:0] HALF_HI = 2'd0;
    localparam logic [1:0] HALF_LO = 2'd2;

    function automatic logic lsu_is_load(input lsu_op_e op);
        return (op == LSU_LW) || (op == LSU_LH) || (op == LSU_LHU) ||
               (op == LSU_LB) || (op == LSU_LBU);
    endfunction

    function automatic logic lsu_addr_err(input lsu_op_e op, input logic [31:0] addr,
                                          input int unsigned mem_words);
        logic misaligned;
        case (op)
            LSU_LW, LSU_SW:          misaligned = (addr[1:0] != 2'b00);
            LSU_LH, LSU_LHU, LSU_SH: misaligned = addr[0];
            default:                 misaligned = 1'b0;
        endcase
        return misaligned || ({2'b00, addr[31:2]} >= mem_words);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: merges store data into a memory word and extracts
// sign- or zero-extended load values from one.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  lsu_op_e     op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] store_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (offset_i)
            LANE_B0: byte_sel = word_i[31:24];
            LANE_B1: byte_sel = word_i[23:16];
            LANE_B2: byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = (offset_i[1] == HALF_LO[1]) ? word_i[15:0] : word_i[31:16];

        load_o = word_i;
        case (op_i)
            LSU_LH:  load_o = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: load_o = {16'h0000, half_sel};
            LSU_LB:  load_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: load_o = {24'h000000, byte_sel};
            default: load_o = word_i;
        endcase

        store_o = word_i;
        if (op_i == LSU_SH) begin
            if (offset_i[1] == HALF_HI[1]) store_o[31:16] = wdata_i;
            else                           store_o[15:0]  = wdata_i;
        end else if (op_i == LSU_SB) begin
            case (offset_i)
                LANE_B0: store_o[31:24] = wdata_i[7:0];
                LANE_B1: store_o[23:16] = wdata_i[7:0];
                LANE_B2: store_o[15:8]  = wdata_i[7:0];
                default: store_o[7:0]   = wdata_i[7:0];
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-only memory; sub-word stores
// are done as read-modify-write, bad addresses complete with an error and no access.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q;
    logic [1:0]  offset_q;
    logic [15:0] wdata_q;
    logic [31:0] rbuf_q;
    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q, mem_address_q, mem_write_data_q;

    lsu_op_e     req_op_e;
    logic        req_err;
    logic [31:0] align_word, store_word, load_data;

    assign req_op_e = lsu_op_e'(req_op);
    assign req_err  = lsu_addr_err(req_op_e, req_addr, MEM_WORDS);

    // The live read word is aligned during RD so results can be registered on that edge
    assign align_word = (state_q == RD) ? mem_read_data : rbuf_q;

    lsu_lane_align u_align (
        .op_i     (op_q),
        .offset_i (offset_q),
        .word_i   (align_word),
        .wdata_i  (wdata_q),
        .store_o  (store_word),
        .load_o   (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                   state_d = RESP;
                    else if (req_op_e == LSU_SW)   state_d = WR;
                    else                           state_d = RD;
                end
            end
            RD:      state_d = lsu_is_load(op_q) ? RESP : WR;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= IDLE;
            op_q             <= LSU_LW;
            offset_q         <= 2'b00;
            wdata_q          <= 16'h0000;
            rbuf_q           <= 32'h0;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= 32'h0;
            mem_address_q    <= 32'h0;
            mem_write_data_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_d == RESP);
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q             <= req_op_e;
                        offset_q         <= req_addr[1:0];
                        wdata_q          <= req_wdata[15:0];
                        mem_address_q    <= {req_addr[31:2], 2'b00};
                        mem_write_data_q <= (req_op_e == LSU_SW && !req_err) ? req_wdata : 32'h0;
                        resp_err_q       <= req_err;
                    end
                end
                RD: begin
                    rbuf_q <= mem_read_data;
                    if (lsu_is_load(op_q)) resp_rdata_q     <= load_data;
                    else                   mem_write_data_q <= store_word;
                end
                default: ;
            endcase
        end
    end

    // Strobes come straight from state so a reset cycle can never commit an access
    assign mem_read       = (state_q == RD) && !RST;
    assign mem_write      = (state_q == WR) && !RST;
    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 64-word combinational-read memory model.
module tb_load_store_unit;

    localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                           OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid, resp_err, mem_write, mem_read;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem [64];
    int checks = 0;
    int failures = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, misal_cnt = 0;
    int rd0, wr0, lat, n;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .CLK            (clk),
        .RST            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = (mem_address[31:8] == 24'h0) ? mem[mem_address[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[1]  <= 32'd12;
            mem[2]  <= 32'h0000_0147;
            mem[5]  <= 32'h0000_B9DF;
            mem[63] <= 32'h1357_9BDF;
        end else if (mem_write) begin
            mem[mem_address[7:2]] <= mem_write_data;
        end
    end

    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read && mem_write) both_cnt++;
        if ((mem_read || mem_write) && mem_address[1:0] != 2'b00) misal_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    endtask

    // Leaves time at #1 after the accept edge
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd);
        wait_ready(tag);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int l);
        l = 1;
        while (!resp_valid && l < 10) begin
            @(posedge clk); #1; l++;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int exp_lat,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int l;
        issue(tag, op, addr, wd);
        wait_resp(l);
        check({tag, "_lat"}, l, exp_lat);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
        $display("txn %s op=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0b",
                 tag, op, addr, wd, l, resp_rdata, resp_err);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        rst = 1'b0;

        check("rst_ready", {31'h0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", {31'h0, resp_err}, 32'd0);
        check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);

        do_op("LW04",  OP_LW,  32'h04, 32'h0, 2, 32'h0000_000C, 1'b0);
        do_op("LBU0B", OP_LBU, 32'h0B, 32'h0, 2, 32'h0000_0047, 1'b0);
        do_op("LB0A",  OP_LB,  32'h0A, 32'h0, 2, 32'h0000_0001, 1'b0);
        do_op("LH16",  OP_LH,  32'h16, 32'h0, 2, 32'hFFFF_B9DF, 1'b0);
        do_op("LHU16", OP_LHU, 32'h16, 32'h0, 2, 32'h0000_B9DF, 1'b0);
        do_op("LB17",  OP_LB,  32'h17, 32'h0, 2, 32'hFFFF_FFDF, 1'b0);
        do_op("LW_FC", OP_LW,  32'hFC, 32'h0, 2, 32'h1357_9BDF, 1'b0);

        rd0 = rd_cnt; wr0 = wr_cnt;
        do_op("SB08", OP_SB, 32'h08, 32'hFFFF_FFAA, 3, 32'h0, 1'b0);
        check("SB08_mem", mem[2], 32'hAA00_0147);
        check("SB08_reads", rd_cnt - rd0, 1);
        check("SB08_writes", wr_cnt - wr0, 1);
        do_op("LW08", OP_LW, 32'h08, 32'h0, 2, 32'hAA00_0147, 1'b0);

        do_op("SH16", OP_SH, 32'h16, 32'hCAFE_1234, 3, 32'h0, 1'b0);
        check("SH16_mem", mem[5], 32'h0000_1234);
        do_op("LW14", OP_LW, 32'h14, 32'h0, 2, 32'h0000_1234, 1'b0);

        rd0 = rd_cnt; wr0 = wr_cnt;
        do_op("LW06_err",  OP_LW, 32'h06,  32'h0, 1, 32'h0, 1'b1);
        do_op("SH05_err",  OP_SH, 32'h05,  32'hBEEF, 1, 32'h0, 1'b1);
        do_op("LW100_err", OP_LW, 32'h100, 32'h0, 1, 32'h0, 1'b1);
        check("err_reads", rd_cnt - rd0, 0);
        check("err_writes", wr_cnt - wr0, 0);

        // Reset lands in the WR cycle of a word store
        wr0 = wr_cnt;
        issue("SW10_rst", OP_SW, 32'h10, 32'd5);
        check("SW10_in_wr", {31'h0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        check("SW10_wr_gated", {31'h0, mem_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("SW10_mem", mem[4], 32'h0);
        check("SW10_writes", wr_cnt - wr0, 0);
        check("SW10_ready", {31'h0, req_ready}, 32'd1);
        check("SW10_outs", {29'h0, resp_valid, resp_err, mem_read}, 32'd0);
        check("SW10_rdata", resp_rdata, 32'h0);
        check("SW10_addr", mem_address, 32'h0);
        check("SW10_wdata", mem_write_data, 32'h0);
        $display("txn SW10_rst op=5 addr=00000010 wdata=00000005 aborted by reset mem4=%h", mem[4]);
        do_op("LW10", OP_LW, 32'h10, 32'h0, 2, 32'h0, 1'b0);

        // req_valid held across two requests
        wait_ready("b2b");
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h0C; req_wdata = 32'h1122_3344;
        @(posedge clk); #1;
        req_op = OP_LW; req_addr = 32'h0C; req_wdata = 32'h0;
        check("b2b_busy", {31'h0, req_ready}, 32'd0);
        wait_resp(lat);
        check("b2b_sw_lat", lat, 2);
        check("b2b_sw_err", {31'h0, resp_err}, 32'd0);
        check("b2b_resp_busy", {31'h0, req_ready}, 32'd0);
        $display("txn b2b_SW0C op=5 addr=0000000c wdata=11223344 lat=%0d err=%0b", lat, resp_err);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!resp_valid && n < 10);
        req_valid = 1'b0;
        check("b2b_lw_gap", n, 3);
        check("b2b_lw_rdata", resp_rdata, 32'h1122_3344);
        $display("txn b2b_LW0C op=0 addr=0000000c gap=%0d rdata=%h", n, resp_rdata);

        @(posedge clk); #1;
        check("rw_overlap", both_cnt, 0);
        check("addr_aligned", misal_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
